// File: rtl/cgra_config_sequencer.sv
// cgra_config_sequencer
// Streams (address, data) configuration pairs from a host/boot source into the
// CGRA fabric config bus. Pairs are buffered in a small FIFO, written out one
// per slot with a programmable minimum spacing, and an END_ADDR marker closes
// the session and raises a sticky done flag.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset; nothing accepted, waiting for start
// RUN   | accepting pairs until END_ADDR, issuing cfg_we writes from FIFO
// DONE  | stream complete and drained; done held until start or reset
module cgra_config_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 8,
    parameter int                HOLD     = 1,
    parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_we,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_written
);

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;
    // Hold counter sized to hold HOLD-1; a HOLD of 1 never loads a nonzero value.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              end_seen;
    logic [HW-1:0]     hold_cnt;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              fifo_empty;
    logic              fifo_full;
    logic              in_run;
    logic              is_end;
    logic              accept;
    logic              push;
    logic              issue;
    logic              finish;

    // FIFO status, handshake and issue decisions, all derived from current state.
    always_comb begin
        wr_idx     = wr_ptr[IW-1:0];
        rd_idx     = rd_ptr[IW-1:0];
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
        in_run     = (state == S_RUN);
        in_ready   = in_run && !fifo_full && !end_seen;
        is_end     = (in_addr == END_ADDR);
        accept     = in_valid && in_ready;
        push       = accept && !is_end;
        issue      = in_run && !fifo_empty && (hold_cnt == '0);
        finish     = end_seen && fifo_empty && (hold_cnt == '0) && !issue;
        busy       = in_run;
        done       = (state == S_DONE);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_addr[wr_idx] <= in_addr;
            mem_data[wr_idx] <= in_data;
        end
    end

    // Session FSM with FIFO pointers, hold timer and registered fabric outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            end_seen      <= 1'b0;
            hold_cnt      <= '0;
            cfg_addr      <= '0;
            cfg_data      <= '0;
            cfg_we        <= 1'b0;
            words_written <= '0;
        end else begin
            cfg_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        end_seen      <= 1'b0;
                        hold_cnt      <= '0;
                        cfg_addr      <= '0;
                        cfg_data      <= '0;
                        words_written <= '0;
                    end
                end
                S_RUN: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    if (accept && is_end) begin
                        end_seen <= 1'b1;
                    end
                    if (issue) begin
                        rd_ptr   <= rd_ptr + PW'(1);
                        cfg_addr <= mem_addr[rd_idx];
                        cfg_data <= mem_data[rd_idx];
                        cfg_we   <= 1'b1;
                        hold_cnt <= HOLD_LOAD;
                        if (words_written != 16'hFFFF) begin
                            words_written <= words_written + 16'd1;
                        end
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                    if (finish) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench for cgra_config_sequencer: one instance with HOLD=1 and one
// with HOLD=4 share the clock, reset and pair bus; sel steers start/in_valid.
module tb_cgra_config_sequencer;

    localparam logic [31:0] END = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        sel;
    logic [31:0] in_addr;
    logic [31:0] in_data;

    logic        rdy1, we1, busy1, done1;
    logic [31:0] ca1, cd1;
    logic [15:0] ww1;
    logic        rdy4, we4, busy4, done4;
    logic [31:0] ca4, cd4;
    logic [15:0] ww4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cgra_config_sequencer #(.HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .start(start && !sel),
        .in_valid(in_valid && !sel), .in_ready(rdy1),
        .in_addr(in_addr), .in_data(in_data),
        .cfg_addr(ca1), .cfg_data(cd1), .cfg_we(we1),
        .busy(busy1), .done(done1), .words_written(ww1)
    );

    cgra_config_sequencer #(.HOLD(4)) u_h4 (
        .clk(clk), .reset(reset), .start(start && sel),
        .in_valid(in_valid && sel), .in_ready(rdy4),
        .in_addr(in_addr), .in_data(in_data),
        .cfg_addr(ca4), .cfg_data(cd4), .cfg_we(we4),
        .busy(busy4), .done(done4), .words_written(ww4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int idx, cyc, last_we, n_we, done_cyc;
        logic rdy_b;

        // 1: reset held with start/in_valid high
        reset = 1'b0; start = 1'b1; in_valid = 1'b1; sel = 1'b0;
        in_addr = 32'h10; in_data = 32'h0;
        repeat (4) step();
        chk("rst_we", we1, 0);
        chk("rst_ready", rdy1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_addr", ca1, 0);
        chk("rst_busy_h4", busy4, 0);
        start = 1'b0; in_valid = 1'b0; reset = 1'b1;
        step();
        chk("idle_busy", busy1, 0);

        // 2: HOLD=1 back-to-back stream
        start = 1'b1;
        step();
        chk("t2_busy", busy1, 1);
        chk("t2_ready", rdy1, 1);
        start = 1'b0; in_valid = 1'b1; in_addr = 32'h10; in_data = 32'hAAAA_0001;
        step();
        chk("t2_we_lat0", we1, 0);
        in_addr = 32'h11; in_data = 32'hAAAA_0002;
        step();
        chk("t2_we1", we1, 1);
        chk("t2_addr1", ca1, 32'h10);
        chk("t2_data1", cd1, 32'hAAAA_0001);
        in_addr = 32'h12; in_data = 32'hAAAA_0003;
        step();
        chk("t2_we2", we1, 1);
        chk("t2_addr2", ca1, 32'h11);
        in_addr = END; in_data = 32'h1234_5678;
        step();
        chk("t2_we3", we1, 1);
        chk("t2_addr3", ca1, 32'h12);
        chk("t2_data3", cd1, 32'hAAAA_0003);
        chk("t2_ready_after_end", rdy1, 0);
        in_valid = 1'b0;
        step();
        chk("t2_we_off", we1, 0);
        chk("t2_done", done1, 1);
        chk("t2_busy_off", busy1, 0);
        chk("t2_words", ww1, 3);
        chk("t2_addr_held", ca1, 32'h12);

        // 6: start in DONE restarts; start in RUN is ignored
        start = 1'b1;
        step();
        chk("t6_done_clr", done1, 0);
        chk("t6_busy", busy1, 1);
        chk("t6_words_clr", ww1, 0);
        chk("t6_addr_clr", ca1, 0);
        start = 1'b0; in_valid = 1'b1; in_addr = 32'h20; in_data = 32'h0000_0001;
        step();
        in_valid = 1'b0; start = 1'b1;
        step();
        chk("t6_we", we1, 1);
        chk("t6_words1", ww1, 1);
        step();
        chk("t6_ignored_busy", busy1, 1);
        chk("t6_ignored_words", ww1, 1);
        chk("t6_ignored_addr", ca1, 32'h20);
        start = 1'b0; in_valid = 1'b1; in_addr = END;
        step();
        in_valid = 1'b0;
        step();
        chk("t6_done", done1, 1);
        chk("t6_words_final", ww1, 1);

        // 4: empty session
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; in_addr = END;
        step();
        chk("t4_we", we1, 0);
        chk("t4_done_early", done1, 0);
        chk("t4_ready", rdy1, 0);
        in_valid = 1'b0;
        step();
        chk("t4_done", done1, 1);
        chk("t4_words", ww1, 0);
        chk("t4_we_after", we1, 0);

        // 5: reset mid-session
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; in_addr = 32'h30; in_data = 32'h3;
        step();
        in_addr = 32'h31;
        step();
        chk("t5_we_a", we1, 1);
        in_addr = 32'h32;
        step();
        chk("t5_we_b", we1, 1);
        chk("t5_addr_b", ca1, 32'h31);
        reset = 1'b0; in_valid = 1'b0;
        step();
        chk("t5_rst_we", we1, 0);
        chk("t5_rst_busy", busy1, 0);
        chk("t5_rst_addr", ca1, 0);
        chk("t5_rst_words", ww1, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_we", we1, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b1; in_addr = 32'h40; in_data = 32'h4;
        step();
        chk("t5_new_lat0", we1, 0);
        in_addr = 32'h41;
        step();
        chk("t5_new_addr0", ca1, 32'h40);
        chk("t5_new_we0", we1, 1);
        in_addr = END;
        step();
        chk("t5_new_addr1", ca1, 32'h41);
        in_valid = 1'b0;
        step();
        chk("t5_done", done1, 1);
        chk("t5_words", ww1, 2);

        // 3: HOLD=4, 12 pairs offered continuously
        sel = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_busy", busy4, 1);
        idx = 0; cyc = 0; last_we = 0; n_we = 0; done_cyc = -1;
        while (cyc < 80 && done_cyc < 0) begin
            in_valid = (idx <= 12);
            in_addr  = (idx < 12) ? 32'h100 + 32'(idx) : END;
            in_data  = 32'hD000_0000 + 32'(idx);
            rdy_b    = rdy4;
            step();
            cyc++;
            if (rdy_b && in_valid) idx++;
            if (cyc == 10) chk("t3_ready_c10", rdy4, 1);
            if (cyc == 11) chk("t3_full_c11", rdy4, 0);
            if (cyc == 13) chk("t3_full_c13", rdy4, 0);
            if (we4) begin
                chk("t3_addr", ca4, 32'h100 + 32'(n_we));
                chk("t3_data", cd4, 32'hD000_0000 + 32'(n_we));
                if (n_we == 0) chk("t3_first_we", cyc, 2);
                else           chk("t3_gap", cyc - last_we, 4);
                last_we = cyc;
                n_we++;
            end
            if (done4) done_cyc = cyc;
        end
        in_valid = 1'b0;
        chk("t3_pulses", n_we, 12);
        chk("t3_words", ww4, 12);
        chk("t3_done_cyc", done_cyc, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cgra_config_sequencer.md
Name: cgra_config_sequencer

Overview:
- Streaming configuration loader for the CGRA tile array.
- Accepts (address, data) configuration pairs from a host or boot source over a valid/ready interface and buffers them in a small FIFO.
- Issues them to the fabric's config_addr/config_data bus one write per slot, with a programmable minimum spacing.
- Detects an end-of-configuration marker and reports completion, which replaces file-driven loading of the fabric.

Parameters:
- ADDR_W, 32, width of configuration address.
- DATA_W, 32, width of configuration data.
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- HOLD, 1, minimum cycles between consecutive cfg_we pulses; >= 1.
- END_ADDR, 32'hFFFFFFFF, address value marking end of a configuration stream.

Ports:
- clk  in  1  clock.
- reset  in  1  Synchronous, active-low reset.
- start  in  1  Begin a configuration session. Level sampled; acts only in IDLE or DONE.
- in_valid  in  1  Input pair valid.
- in_ready  out  1  Sequencer can accept a pair.
- in_addr  in  ADDR_W  Configuration address.
- in_data  in  DATA_W  Configuration data.
- cfg_addr  out  ADDR_W  Address driven to fabric.
- cfg_data  out  DATA_W  Data driven to fabric.
- cfg_we  out  1  One-cycle write strobe to fabric.
- busy  out  1  High in RUN.
- done  out  1  High in DONE; sticky until next start or reset.
- words_written  out  16  cfg_we pulses issued this session; saturates at 16'hFFFF.

Behaviour:
- Reset: the block is in reset while reset == 0, sampled on the rising edge of clk.
  - Resets to IDLE and empties the FIFO; end_seen = 0, hold counter = 0.
  - All outputs are 0, including in_ready.
  - Reset asserted mid-session aborts immediately. Queued words are discarded and no further cfg_we is issued.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready = 0, busy = 0, done = 0. start -> RUN.
  - RUN: busy = 1. Exits to DONE when end_seen && FIFO empty && hold counter == 0 && no issue in this cycle.
  - DONE: done = 1, busy = 0, in_ready = 0. start -> RUN.
  - start while in RUN is ignored.
- Entering RUN (on the start edge): clears words_written, end_seen, the FIFO, cfg_addr and cfg_data; cfg_we = 0.
- Accept (RUN only):
  - in_ready = !full && !end_seen.
  - A transfer occurs on a cycle with in_valid && in_ready.
  - No push when full, even if a pop occurs in the same cycle.
  - A pair with in_addr == END_ADDR is not enqueued. It sets end_seen; in_data is ignored. After end_seen, in_ready stays 0 for the rest of the session.
- Issue:
  - Occurs when the FIFO is non-empty and the hold counter == 0.
  - On issue: pop the head, register it to cfg_addr/cfg_data, pulse cfg_we for exactly 1 cycle, load hold counter = HOLD-1, increment words_written.
  - The hold counter decrements each cycle while > 0.
  - Consecutive cfg_we pulses are therefore exactly HOLD cycles apart under a full FIFO.
- Latency: a pair accepted at edge t, into an empty FIFO with the hold counter at 0, produces cfg_we high in the cycle after t (1-cycle latency). Simultaneous push and pop are allowed when not full.
- cfg_addr/cfg_data hold the last issued value between pulses and in DONE. They are cleared only by reset or start.
- Ordering: strict FIFO. Pointer wrap-around uses an extra MSB for full/empty discrimination.
- done rises the cycle after the later of:
  - the final cfg_we pulse (with its hold window elapsed),
  - END_ADDR acceptance.

Test Plan:
1. Reset: reset = 0 for 4 cycles with in_valid = 1 and start = 1 -> cfg_we, in_ready, busy, done all 0; cfg_addr = 0.
2. HOLD=1, start, then back-to-back pairs (0x10, 0xAAAA0001), (0x11, 0xAAAA0002), (0x12, 0xAAAA0003), then END_ADDR -> cfg_we high on 3 consecutive cycles starting 1 cycle after the first accept, addresses 0x10, 0x11, 0x12 in order. done = 1 on the cycle after the third pulse; words_written = 3.
3. DEPTH=8, HOLD=4, 12 pairs offered continuously -> in_ready drops while the FIFO holds 8 entries; cfg_we pulses exactly 4 cycles apart; all 12 pairs appear in order; words_written = 12.
4. Empty session: start, then END_ADDR as the first pair -> no cfg_we; done = 1 on the cycle after END acceptance.
5. Reset mid-session: after 2 of 6 pairs are issued, assert reset for 1 cycle -> no further cfg_we. A new start followed by 2 pairs + END gives words_written = 2, with only the new addresses issued.
6. start pulsed during RUN -> ignored, counter not cleared. start in DONE -> done = 0, busy = 1, words_written = 0, cfg_addr = 0.
